datapath: RTL and testbench

//  Execution datapath directly downstream of control_unit. It consumes control_unit's

---
 rtl/datapath_if.sv | 33 +++
 rtl/datapath.sv | 81 ++++++++
 tb/tb_datapath.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Control/status bundle between control_unit and the execution datapath.
// control_unit drives the master side; the datapath implements the slave side.
interface datapath_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  rf_write;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]     imm_data;
  logic [3:0]            alu_sel;
  logic                  imm_sel;
  logic                  mem_write;
  logic                  mem_sel;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic                  zero_flag;
  logic                  pos_flag;
  logic [DATA_W-1:0]     result_q;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output rf_write, rs_addr, rt_addr, rd_addr, imm_data, alu_sel,
           imm_sel, mem_write, mem_sel, dbg_addr,
    input  zero_flag, pos_flag, result_q, dbg_data
  );

  modport slave (
    input  rf_write, rs_addr, rt_addr, rd_addr, imm_data, alu_sel,
           imm_sel, mem_write, mem_sel, dbg_addr,
    output zero_flag, pos_flag, result_q, dbg_data
  );
endinterface

// File: rtl/datapath.sv
// Execution datapath: 8x16 register file, ALU, 32-word data memory and write-back mux.
// Execute edge captures result_q / mem_rdata_q; the following rf_write edge commits them.
module datapath #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 5
) (
  input logic       clock,
  input logic       reset,
  datapath_if.slave bus
);
  localparam int NUM_REGS  = 2 ** REG_ADDR_W;
  localparam int NUM_WORDS = 2 ** MEM_ADDR_W;

  logic [DATA_W-1:0]     rf   [NUM_REGS];
  logic [DATA_W-1:0]     dmem [NUM_WORDS];
  logic [DATA_W-1:0]     result_q;
  logic [DATA_W-1:0]     mem_rdata_q;
  logic                  zero_q;
  logic                  pos_q;

  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     st_data;
  logic [DATA_W-1:0]     alu_y;
  logic [DATA_W-1:0]     wb_data;
  logic [MEM_ADDR_W-1:0] mem_addr;

  assign op_a     = rf[bus.rs_addr];
  assign st_data  = rf[bus.rt_addr];
  assign op_b     = bus.imm_sel ? bus.imm_data : st_data;
  // Upper address bits are dropped so the memory address wraps.
  assign mem_addr = op_a[MEM_ADDR_W-1:0];
  assign wb_data  = bus.mem_sel ? mem_rdata_q : result_q;

  always_comb begin
    alu_y = '0;
    case (bus.alu_sel)
      4'h0: alu_y = op_a + op_b;
      4'h1: alu_y = op_a - op_b;
      4'h2: alu_y = op_a & op_b;
      4'h3: alu_y = op_a | op_b;
      4'h4: alu_y = op_a ^ op_b;
      4'h5: alu_y = ~op_a;
      4'h6: alu_y = op_a << 1;
      4'h7: alu_y = op_a >> 1;
      4'h8: alu_y = op_a + DATA_W'(1);
      4'h9: alu_y = op_a - DATA_W'(1);
      4'hA: alu_y = op_a;
      4'hB: alu_y = op_b;
      default: alu_y = '0;
    endcase
  end

  // All reads above use pre-edge state, so same-edge read/write returns the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)  rf[i]   <= '0;
      for (int i = 0; i < NUM_WORDS; i++) dmem[i] <= '0;
      result_q    <= '0;
      mem_rdata_q <= '0;
      zero_q      <= 1'b0;
      pos_q       <= 1'b0;
    end else begin
      result_q    <= alu_y;
      mem_rdata_q <= dmem[mem_addr];
      if (bus.mem_write) dmem[mem_addr] <= st_data;
      if (bus.rf_write)  rf[bus.rd_addr] <= wb_data;
      // Loads leave the flags alone; only ALU write-backs update them.
      if (bus.rf_write && !bus.mem_sel) begin
        zero_q <= (result_q == '0);
        pos_q  <= ~result_q[DATA_W-1] && (result_q != '0);
      end
    end
  end

  assign bus.result_q  = result_q;
  assign bus.zero_flag = zero_q;
  assign bus.pos_flag  = pos_q;
  assign bus.dbg_data  = rf[bus.dbg_addr];
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed instruction sequences plus randomized
// control fields, compared against an arithmetic reference model of the RF/memory.
module tb_datapath;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  datapath_if bus ();

  datapath dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  // Reference model state (plain integers, modulo 2**16 arithmetic).
  int m_rf   [8];
  int m_mem  [32];
  int m_res;
  int m_mrd;
  int m_zero;
  int m_pos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0:  return (a + b) % 65536;
      1:  return (a - b + 65536) % 65536;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return 65535 - a;
      6:  return (a * 2) % 65536;
      7:  return a / 2;
      8:  return (a + 1) % 65536;
      9:  return (a + 65535) % 65536;
      10: return a;
      11: return b;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++)  m_rf[i]  = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_res = 0; m_mrd = 0; m_zero = 0; m_pos = 0;
  endtask

  task automatic set_ctl(input bit rfw, input int rs, input int rt, input int rd,
                         input int imm, input int alu, input bit isel,
                         input bit mw, input bit msel);
    bus.rf_write  = rfw;
    bus.rs_addr   = 3'(rs);
    bus.rt_addr   = 3'(rt);
    bus.rd_addr   = 3'(rd);
    bus.imm_data  = 16'(imm);
    bus.alu_sel   = 4'(alu);
    bus.imm_sel   = isel;
    bus.mem_write = mw;
    bus.mem_sel   = msel;
  endtask

  task automatic sweep(input string tag);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = 3'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), {16'h0, bus.dbg_data}, 32'(m_rf[r]));
    end
  endtask

  // One clock edge: advance the model from pre-edge state, then compare.
  task automatic tick(input string tag);
    int a, b, addr, nres, nmrd, wb;
    a    = m_rf[bus.rs_addr];
    b    = bus.imm_sel ? int'(bus.imm_data) : m_rf[bus.rt_addr];
    addr = a % 32;
    nres = alu_ref(int'(bus.alu_sel), a, b);
    nmrd = m_mem[addr];
    wb   = bus.mem_sel ? m_mrd : m_res;
    if (bus.mem_write) m_mem[addr] = m_rf[bus.rt_addr];
    if (bus.rf_write && !bus.mem_sel) begin
      m_zero = (m_res == 0);
      m_pos  = (m_res != 0 && m_res < 32768);
    end
    if (bus.rf_write) m_rf[bus.rd_addr] = wb;
    m_res = nres;
    m_mrd = nmrd;
    @(posedge clock);
    #1;
    chk({tag, "_res"},  {16'h0, bus.result_q}, 32'(m_res));
    chk({tag, "_zero"}, {31'h0, bus.zero_flag}, 32'(m_zero));
    chk({tag, "_pos"},  {31'h0, bus.pos_flag},  32'(m_pos));
    sweep(tag);
  endtask

  // Execute edge then write-back edge with identical control fields.
  task automatic alu_instr(input string tag, input int rs, input int rt, input int rd,
                           input int imm, input int alu, input bit isel);
    set_ctl(1'b0, rs, rt, rd, imm, alu, isel, 1'b0, 1'b0);
    tick({tag, "_ex"});
    bus.rf_write = 1'b1;
    tick({tag, "_wb"});
    bus.rf_write = 1'b0;
  endtask

  task automatic peek(input int r, output logic [15:0] v);
    bus.dbg_addr = 3'(r);
    #1;
    v = bus.dbg_data;
  endtask

  initial begin
    logic [15:0] v;
    logic        z_save, p_save;
    model_reset();
    set_ctl(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    bus.dbg_addr = '0;
    #25;
    reset = 1'b0;
    #1;
    chk("rst_res",  {16'h0, bus.result_q}, 32'h0);
    chk("rst_zero", {31'h0, bus.zero_flag}, 32'h0);
    chk("rst_pos",  {31'h0, bus.pos_flag},  32'h0);
    sweep("rst");

    // MOVI R3,#5
    alu_instr("movi", 0, 0, 3, 5, 11, 1'b1);
    peek(3, v);
    chk("movi_r3", {16'h0, v}, 32'h0005);
    chk("movi_z", {31'h0, bus.zero_flag}, 32'h0);
    chk("movi_p", {31'h0, bus.pos_flag},  32'h1);

    // SUB R4,R3,R3
    alu_instr("sub", 3, 3, 4, 0, 1, 1'b0);
    peek(4, v);
    chk("sub_r4", {16'h0, v}, 32'h0000);
    chk("sub_z", {31'h0, bus.zero_flag}, 32'h1);
    chk("sub_p", {31'h0, bus.pos_flag},  32'h0);

    // DEC R5,R4 -> negative
    alu_instr("dec", 4, 0, 5, 0, 9, 1'b0);
    peek(5, v);
    chk("dec_r5", {16'h0, v}, 32'hFFFF);
    chk("dec_z", {31'h0, bus.zero_flag}, 32'h0);
    chk("dec_p", {31'h0, bus.pos_flag},  32'h0);

    // 0x7FFF + 1 overflows into the sign bit
    alu_instr("ld7f", 0, 0, 1, 16'h7FFF, 11, 1'b1);
    alu_instr("addov", 1, 0, 2, 1, 0, 1'b1);
    peek(2, v);
    chk("addov_r2", {16'h0, v}, 32'h8000);
    chk("addov_p", {31'h0, bus.pos_flag},  32'h0);
    chk("addov_z", {31'h0, bus.zero_flag}, 32'h0);

    // Store R2 to dmem[R1 wraps to 3], then load into R6
    alu_instr("ld23", 0, 0, 1, 16'h0023, 11, 1'b1);
    alu_instr("ldbe", 0, 0, 2, 16'hBEEF, 11, 1'b1);
    z_save = bus.zero_flag;
    p_save = bus.pos_flag;
    set_ctl(1'b0, 1, 2, 0, 0, 10, 1'b0, 1'b1, 1'b0);
    tick("st");
    set_ctl(1'b0, 1, 2, 6, 0, 10, 1'b0, 1'b0, 1'b1);
    tick("ldrd");
    bus.rf_write = 1'b1;
    tick("ldwb");
    bus.rf_write = 1'b0;
    peek(6, v);
    chk("ld_r6", {16'h0, v}, 32'hBEEF);
    chk("ld_z", {31'h0, bus.zero_flag}, {31'h0, z_save});
    chk("ld_p", {31'h0, bus.pos_flag},  {31'h0, p_save});

    // Same-edge hazard on R7
    alu_instr("r7a", 0, 0, 7, 16'h0011, 11, 1'b1);
    set_ctl(1'b0, 0, 0, 7, 16'h0022, 11, 1'b1, 1'b0, 1'b0);
    tick("r7b_ex");
    set_ctl(1'b1, 7, 0, 7, 0, 10, 1'b0, 1'b0, 1'b0);
    tick("haz_wb");
    chk("haz_old", {16'h0, bus.result_q}, 32'h0011);
    bus.rf_write = 1'b0;
    tick("haz_next");
    chk("haz_new", {16'h0, bus.result_q}, 32'h0022);

    // Reset asserted across a write-back edge: everything clears, no write lands
    set_ctl(1'b1, 0, 0, 3, 16'h1234, 11, 1'b1, 1'b1, 1'b0);
    #14;
    reset = 1'b1;
    #1;
    model_reset();
    chk("ar_res",  {16'h0, bus.result_q}, 32'h0);
    chk("ar_zero", {31'h0, bus.zero_flag}, 32'h0);
    chk("ar_pos",  {31'h0, bus.pos_flag},  32'h0);
    peek(3, v);
    chk("ar_r3", {16'h0, v}, 32'h0);
    #5;
    reset = 1'b0;
    set_ctl(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    sweep("ar_after");

    // Randomized control sequences
    for (int n = 0; n < 400; n++) begin
      set_ctl(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      tick($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
